fir_parallel_block: RTL and testbench

FIR_PARALLEL_BLOCK -- requirements
Module: fir_parallel_block

---
 rtl/fir_parallel_block.sv | 122 ++++++++++++
 tb/tb_fir_parallel_block.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_parallel_block.sv
// Parallel-lane FIR filter that consumes and produces LANES samples per clock.
// Coefficients are written into a shadow bank and become active on commit,
// so the taps can be reloaded while the filter keeps streaming.
module fir_parallel_block #(
  parameter int TAPS  = 96,
  parameter int LANES = 3,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int OW    = 32,
  parameter int SHIFT = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic [LANES*DW-1:0]                    x_in,
  input  logic                                   coeff_wr,
  input  logic [(TAPS > 1 ? $clog2(TAPS) : 1)-1:0] coeff_addr,
  input  logic [CW-1:0]                          coeff_data,
  input  logic                                   coeff_commit,
  input  logic                                   flush,
  output logic                                   coeff_pending,
  output logic                                   out_valid,
  output logic [LANES*OW-1:0]                    y_out
);

  localparam int ACCW = DW + CW + $clog2(TAPS);
  localparam int HL   = TAPS + LANES - 1;
  localparam int RS   = (SHIFT > 0) ? SHIFT - 1 : 0;

  // Rounding offset: half an output LSB, or nothing when no shift is applied.
  localparam logic signed [ACCW:0] RND  = (SHIFT > 0) ? ((ACCW+1)'(1) <<< RS) : '0;
  localparam logic signed [ACCW:0] SMAX = {{(ACCW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW:0] SMIN = {{(ACCW-OW+2){1'b1}}, {(OW-1){1'b0}}};

  // One extra bit keeps the rounding add from wrapping at the extremes.
  function automatic logic signed [ACCW:0] round_shift(input logic signed [ACCW-1:0] a);
    logic signed [ACCW:0] t;
    t = (ACCW+1)'(a) + RND;
    return t >>> SHIFT;
  endfunction

  function automatic logic signed [OW-1:0] saturate(input logic signed [ACCW:0] v);
    if (v > SMAX)      return {1'b0, {(OW-1){1'b1}}};
    else if (v < SMIN) return {1'b1, {(OW-1){1'b0}}};
    else               return v[OW-1:0];
  endfunction

  logic signed [DW-1:0]   hist_p1 [HL];
  logic                   vld_p1;
  logic signed [CW-1:0]   shadow  [TAPS];
  logic signed [CW-1:0]   active  [TAPS];
  logic signed [ACCW-1:0] acc_p1  [LANES];
  logic [31:0]            addr_w;
  logic                   wr_ok;

  // Out-of-range tap indices are dropped and do not mark the bank dirty.
  assign addr_w = 32'(coeff_addr);
  assign wr_ok  = coeff_wr && (addr_w < 32'(TAPS));

  // Stage 1: shift LANES new samples into the history (index HL-1 newest).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      for (int i = 0; i < HL; i++) hist_p1[i] <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      for (int i = 0; i < HL; i++) hist_p1[i] <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < TAPS - 1; i++) hist_p1[i] <= hist_p1[i+LANES];
        for (int k = 0; k < LANES; k++) hist_p1[TAPS-1+k] <= x_in[k*DW +: DW];
      end
    end
  end

  // Shadow writes and commit; a write on the commit cycle lands in the copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coeff_pending <= 1'b0;
      for (int j = 0; j < TAPS; j++) begin
        shadow[j] <= '0;
        active[j] <= '0;
      end
    end else begin
      if (wr_ok) shadow[coeff_addr] <= coeff_data;
      if (coeff_commit) begin
        coeff_pending <= 1'b0;
        for (int j = 0; j < TAPS; j++)
          active[j] <= (wr_ok && addr_w == 32'(j)) ? coeff_data : shadow[j];
      end else if (wr_ok) begin
        coeff_pending <= 1'b1;
      end
    end
  end

  // Full-width dot product per lane; lane k ends at history index TAPS-1+k.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      acc_p1[k] = '0;
      for (int j = 0; j < TAPS; j++)
        acc_p1[k] = acc_p1[k] + ACCW'(hist_p1[TAPS-1+k-j]) * ACCW'(active[j]);
    end
  end

  // Stage 2: round, saturate and register the outputs; hold y_out when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      y_out     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        for (int k = 0; k < LANES; k++)
          y_out[k*OW +: OW] <= saturate(round_shift(acc_p1[k]));
      end
    end
  end

endmodule

// File: tb/tb_fir_parallel_block.sv
// Bench for fir_parallel_block: two instances (SHIFT=0 and SHIFT=1) share the
// stimulus and are compared every cycle against a sample-stream convolution model.
module tb_fir_parallel_block;

  localparam int TAPS = 4, LANES = 2, DW = 16, CW = 16, OW = 16;

  logic        clk = 1'b0;
  logic        rst, in_valid, coeff_wr, coeff_commit, flush;
  logic [31:0] x_in;
  logic [1:0]  coeff_addr;
  logic [15:0] coeff_data;
  logic        pend0, pend1, ov0, ov1;
  logic [31:0] y0, y1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fir_parallel_block #(.TAPS(TAPS), .LANES(LANES), .DW(DW), .CW(CW), .OW(OW), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .coeff_wr(coeff_wr),
    .coeff_addr(coeff_addr), .coeff_data(coeff_data), .coeff_commit(coeff_commit),
    .flush(flush), .coeff_pending(pend0), .out_valid(ov0), .y_out(y0));

  fir_parallel_block #(.TAPS(TAPS), .LANES(LANES), .DW(DW), .CW(CW), .OW(OW), .SHIFT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .coeff_wr(coeff_wr),
    .coeff_addr(coeff_addr), .coeff_data(coeff_data), .coeff_commit(coeff_commit),
    .flush(flush), .coeff_pending(pend1), .out_valid(ov1), .y_out(y1));

  // Reference model state: the accepted sample stream and the two coefficient banks.
  longint smp[$];
  longint sh[TAPS];
  longint ac[TAPS];
  bit     m_pend, beat_p, m_ov;
  int     beat_n;
  longint m_y[2][LANES];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sample(input int i);
    if (i < 0 || i >= smp.size()) return 0;
    return smp[i];
  endfunction

  function automatic longint conv(input int idx);
    longint s = 0;
    for (int j = 0; j < TAPS; j++) s += ac[j] * sample(idx - j);
    return s;
  endfunction

  function automatic longint rnd_sat(input longint a, input int s);
    longint v = a;
    if (s > 0) v = (v + (64'sd1 <<< (s - 1))) >>> s;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic model_clear();
    smp.delete();
    for (int j = 0; j < TAPS; j++) begin sh[j] = 0; ac[j] = 0; end
    m_pend = 0; beat_p = 0; m_ov = 0;
    for (int s = 0; s < 2; s++) for (int k = 0; k < LANES; k++) m_y[s][k] = 0;
  endtask

  task automatic model_edge();
    if (flush) m_ov = 0;
    else begin
      m_ov = beat_p;
      if (beat_p)
        for (int s = 0; s < 2; s++)
          for (int k = 0; k < LANES; k++) m_y[s][k] = rnd_sat(conv(beat_n + k), s);
    end
    if (flush) begin
      smp.delete();
      beat_p = 0;
    end else if (in_valid) begin
      beat_n = smp.size();
      for (int k = 0; k < LANES; k++) smp.push_back(longint'($signed(x_in[k*DW +: DW])));
      beat_p = 1;
    end else beat_p = 0;
    if (coeff_wr) sh[coeff_addr] = longint'($signed(coeff_data));
    if (coeff_commit) begin
      for (int j = 0; j < TAPS; j++) ac[j] = sh[j];
      m_pend = 0;
    end else if (coeff_wr) m_pend = 1;
  endtask

  task automatic check_all();
    chk("out_valid0", longint'(ov0), longint'(m_ov));
    chk("out_valid1", longint'(ov1), longint'(m_ov));
    chk("pending0", longint'(pend0), longint'(m_pend));
    chk("pending1", longint'(pend1), longint'(m_pend));
    for (int k = 0; k < LANES; k++) begin
      chk("y_shift0", longint'($signed(y0[k*OW +: OW])), m_y[0][k]);
      chk("y_shift1", longint'($signed(y1[k*OW +: OW])), m_y[1][k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_clear();
    else model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_in();
    in_valid = 0; coeff_wr = 0; coeff_commit = 0; flush = 0;
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1; x_in = {b, a};
    tick();
    in_valid = 0;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    coeff_wr = 1; coeff_addr = 2'(a); coeff_data = d;
    tick();
    coeff_wr = 0;
  endtask

  task automatic load_bank(input logic [15:0] h0, input logic [15:0] h1,
                           input logic [15:0] h2, input logic [15:0] h3);
    wr(0, h0); wr(1, h1); wr(2, h2); wr(3, h3);
    coeff_commit = 1; tick(); coeff_commit = 0;
  endtask

  initial begin
    rst = 0; x_in = '0; coeff_addr = '0; coeff_data = '0;
    idle_in();
    model_clear();

    // Reset state
    tick(); tick();
    chk("rst_ov", longint'(ov0), 0);
    chk("rst_y", longint'(y0), 0);
    rst = 1;

    // Impulse response with h = {1,2,3,4}
    load_bank(16'd1, 16'd2, 16'd3, 16'd4);
    chk("commit_pend_clr", longint'(pend0), 0);
    beat(16'd1, 16'd0);
    chk("imp_latency", longint'(ov0), 0);
    beat(16'd0, 16'd0);
    chk("imp_ov", longint'(ov0), 1);
    chk("imp_l0", longint'($signed(y0[15:0])), 1);
    chk("imp_l1", longint'($signed(y0[31:16])), 2);
    beat(16'd0, 16'd0);
    chk("imp_l0b", longint'($signed(y0[15:0])), 3);
    chk("imp_l1b", longint'($signed(y0[31:16])), 4);
    tick();
    chk("imp_l0c", longint'($signed(y0[15:0])), 0);
    chk("imp_l1c", longint'($signed(y0[31:16])), 0);
    tick();
    chk("imp_ov_drop", longint'(ov0), 0);

    // Saturation at both rails
    load_bank(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
    for (int i = 0; i < 4; i++) beat(16'h7fff, 16'h7fff);
    chk("sat_pos", longint'($signed(y0[31:16])), 32767);
    for (int i = 0; i < 4; i++) beat(16'h8000, 16'h8000);
    chk("sat_neg", longint'($signed(y0[15:0])), -32768);
    tick();

    // Rounding in the SHIFT=1 instance
    flush = 1; tick(); flush = 0;
    load_bank(16'd3, 16'd0, 16'd0, 16'd0);
    beat(16'd1, 16'd0); tick();
    chk("rnd_pos", longint'($signed(y1[15:0])), 2);
    beat(16'hffff, 16'd0); tick();
    chk("rnd_neg", longint'($signed(y1[15:0])), -1);

    // Shadow bank update while streaming
    load_bank(16'd1, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) beat(16'($urandom_range(0, 999)), 16'($urandom_range(0, 999)));
    in_valid = 1;
    x_in = 32'h0005_0007; coeff_wr = 1; coeff_addr = 2'd0; coeff_data = 16'd2; tick();
    coeff_wr = 0;
    chk("shadow_pend", longint'(pend0), 1);
    x_in = 32'h0009_000b; tick();
    chk("shadow_old_l0", longint'($signed(y0[15:0])), 7);
    x_in = 32'h0003_0004; coeff_commit = 1; tick(); coeff_commit = 0;
    chk("shadow_still_old", longint'($signed(y0[15:0])), 11);
    x_in = 32'h0001_0002; tick();
    chk("shadow_new_l1", longint'($signed(y0[31:16])), 6);
    in_valid = 0; tick(); tick();

    // Flush with a coincident beat, then a clean impulse
    load_bank(16'd1, 16'd2, 16'd3, 16'd4);
    beat(16'd9, 16'd9);
    flush = 1; in_valid = 1; x_in = 32'h0007_0007; tick();
    flush = 0; in_valid = 0;
    tick();
    chk("flush_no_ov", longint'(ov0), 0);
    beat(16'd1, 16'd0); tick();
    chk("flush_clean_l0", longint'($signed(y0[15:0])), 1);
    chk("flush_clean_l1", longint'($signed(y0[31:16])), 2);

    // Reset in the middle of a stream
    beat(16'd100, 16'd200);
    in_valid = 1; x_in = 32'h0003_0003;
    rst = 0; #1;
    model_clear(); check_all();
    tick();
    in_valid = 0; rst = 1;
    tick();
    chk("rst_no_stale", longint'(ov0), 0);
    load_bank(16'd1, 16'd0, 16'd0, 16'd0);
    beat(16'd5, 16'd6); tick();
    chk("post_rst_l1", longint'($signed(y0[31:16])), 6);

    // Random traffic: beats, writes, commits and occasional flushes
    for (int c = 0; c < 400; c++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      x_in         = $urandom;
      coeff_wr     = ($urandom_range(0, 7) == 0);
      coeff_addr   = 2'($urandom_range(0, 3));
      coeff_data   = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 31) - 16);
      coeff_commit = ($urandom_range(0, 15) == 0);
      flush        = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle_in();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
